// File: rtl/mc_ctrl_fsm_pkg.sv
// rtl/mc_ctrl_fsm_pkg.sv - Opcodes, ALU codes, states and per-state control words (S_EXC only with MC_EXC_EN)
package mc_ctrl_fsm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_FUNCT, AOP_IMM} aluop_e;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPEEX,
    S_RTYPEWB, S_BEQEX, S_BNEEX, S_IMMEX, S_IMMWB, S_JEX
`ifdef MC_EXC_EN
    , S_EXC
`endif
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       extop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    aluop_e     aluop;
  } ctrl_t;

  // Field order: mem_req iord alusrca alusrcb pcsrc extop regdst memtoreg regwrite aluop
  localparam ctrl_t CW_FETCH   = '{1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, AOP_ADD};
  localparam ctrl_t CW_DECODE  = '{1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, AOP_ADD};
  localparam ctrl_t CW_MEMADR  = '{1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, AOP_ADD};
  localparam ctrl_t CW_MEMACC  = '{1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, AOP_ADD};
  localparam ctrl_t CW_MEMWB   = '{1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, AOP_ADD};
  localparam ctrl_t CW_RTYPEEX = '{1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, AOP_FUNCT};
  localparam ctrl_t CW_RTYPEWB = '{1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, AOP_ADD};
  localparam ctrl_t CW_BRANCH  = '{1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, AOP_SUB};
  localparam ctrl_t CW_IMMEX   = '{1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, AOP_IMM};
  localparam ctrl_t CW_IMMWB   = '{1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, AOP_ADD};
  localparam ctrl_t CW_JEX     = '{1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, AOP_ADD};
  localparam ctrl_t CW_EXC     = '{1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, AOP_ADD};

  // op is the held IR opcode; only IMMEX needs it (logical immediates zero-extend)
  function automatic ctrl_t ctrl_of(state_e s, logic [5:0] op);
    ctrl_t cw;
    case (s)
      S_DECODE:          cw = CW_DECODE;
      S_MEMADR:          cw = CW_MEMADR;
      S_MEMRD, S_MEMWR:  cw = CW_MEMACC;
      S_MEMWB:           cw = CW_MEMWB;
      S_RTYPEEX:         cw = CW_RTYPEEX;
      S_RTYPEWB:         cw = CW_RTYPEWB;
      S_BEQEX, S_BNEEX:  cw = CW_BRANCH;
      S_IMMEX:           cw = CW_IMMEX;
      S_IMMWB:           cw = CW_IMMWB;
      S_JEX:             cw = CW_JEX;
`ifdef MC_EXC_EN
      S_EXC:             cw = CW_EXC;
`endif
      default:           cw = CW_FETCH;
    endcase
    if (s == S_IMMEX) cw.extop = !(op == OP_ANDI || op == OP_ORI);
    return cw;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_aludec.sv
// rtl/mc_ctrl_fsm_aludec.sv - Combinational ALU decoder with illegal-funct flag
module mc_aludec
  import mc_ctrl_fsm_pkg::*;
(
  input  aluop_e     aluop_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucont_o,
  output logic       funct_bad_o
);

  always_comb begin
    alucont_o   = ALU_ADD;
    funct_bad_o = 1'b0;
    case (aluop_i)
      AOP_SUB: alucont_o = ALU_SUB;
      AOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alucont_o = ALU_ADD;
          FN_SUB:  alucont_o = ALU_SUB;
          FN_AND:  alucont_o = ALU_AND;
          FN_OR:   alucont_o = ALU_OR;
          FN_SLT:  alucont_o = ALU_SLT;
          default: funct_bad_o = 1'b1;
        endcase
      end
      AOP_IMM: begin
        case (op_i)
          OP_SLTI: alucont_o = ALU_SLT;
          OP_ANDI: alucont_o = ALU_AND;
          OP_ORI:  alucont_o = ALU_OR;
          default: alucont_o = ALU_ADD;
        endcase
      end
      default: alucont_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - Multicycle MIPS control FSM with memory wait/timeout (MC_EXC_EN enables the EXC trap)
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int ALUC_W  = 3,
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              pcen,
  output logic              irwrite,
  output logic              memwrite,
  output logic              regwrite,
  output logic              alusrca,
  output logic              iord,
  output logic              memtoreg,
  output logic              regdst,
  output logic              extop,
  output logic [1:0]        alusrcb,
  output logic [1:0]        pcsrc,
  output logic [ALUC_W-1:0] alucont,
  output logic              bus_err,
  output logic              exc
);

`ifdef MC_EXC_EN
  localparam state_e BAD_OP_NEXT = S_EXC;
  localparam state_e BAD_FN_NEXT = S_EXC;
`else
  localparam state_e BAD_OP_NEXT = S_FETCH;
  localparam state_e BAD_FN_NEXT = S_RTYPEWB;
`endif

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  ctrl_t             ctrl_q;
  logic [2:0]        alu_code;
  logic              funct_bad;
  logic              mem_state;
  logic              timeout;

  mc_aludec u_aludec (
    .aluop_i     (ctrl_q.aluop),
    .op_i        (op),
    .funct_i     (funct),
    .alucont_o   (alu_code),
    .funct_bad_o (funct_bad)
  );

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // mem_ready in the timeout cycle still completes the access
  assign timeout   = (TIMEOUT != 0) && mem_state && !mem_ready && (wcnt_q == WAIT_W'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_RTYPE:                          state_d = S_RTYPEEX;
          OP_BEQ:                            state_d = S_BEQEX;
          OP_BNE:                            state_d = S_BNEEX;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
          OP_J:                              state_d = S_JEX;
          default:                           state_d = BAD_OP_NEXT;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_RTYPEEX: state_d = funct_bad ? BAD_FN_NEXT : S_RTYPEWB;
      S_IMMEX:   state_d = S_IMMWB;
      default:   state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_FETCH;

    // Any exit from a memory state (or never being in one) restarts the count
    if (mem_state && !mem_ready && !timeout)
      wcnt_d = (wcnt_q == '1) ? wcnt_q : wcnt_q + 1'b1;
    else
      wcnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wcnt_q  <= '0;
      ctrl_q  <= CW_FETCH;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ctrl_q  <= ctrl_of(state_d, op);
    end
  end

  always_comb begin
    irwrite  = 1'b0;
    pcen     = 1'b0;
    memwrite = 1'b0;
    exc      = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      S_MEMWR: memwrite = mem_ready;
      S_BEQEX: pcen = zero;
      S_BNEEX: pcen = !zero;
      S_JEX:   pcen = 1'b1;
`ifdef MC_EXC_EN
      S_EXC: begin
        pcen = 1'b1;
        exc  = 1'b1;
      end
`endif
      default: ;
    endcase
    if (reset) begin
      irwrite  = 1'b0;
      pcen     = 1'b0;
      memwrite = 1'b0;
      exc      = 1'b0;
    end
  end

  assign bus_err  = timeout && !reset;
  assign mem_req  = ctrl_q.mem_req;
  assign iord     = ctrl_q.iord;
  assign alusrca  = ctrl_q.alusrca;
  assign alusrcb  = ctrl_q.alusrcb;
  assign pcsrc    = ctrl_q.pcsrc;
  assign extop    = ctrl_q.extop;
  assign regdst   = ctrl_q.regdst;
  assign memtoreg = ctrl_q.memtoreg;
  assign regwrite = ctrl_q.regwrite;
  assign alucont  = ALUC_W'(alu_code);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - Self-checking bench for mc_ctrl_fsm against a per-instruction cycle-plan model
module tb_mc_ctrl_fsm;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                         BNE = 6'b000101, ADDI = 6'b001000, SLTI = 6'b001010, ANDI = 6'b001100,
                         ORI = 6'b001101, JMP = 6'b000010, BAD = 6'b111111;
  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010, A_SUB = 3'b110, A_SLT = 3'b111;
  // strobe vector: {mem_req, irwrite, pcen, memwrite, regwrite, bus_err, exc}
  localparam logic [6:0] B_MREQ = 7'h40, B_IRW = 7'h20, B_PCEN = 7'h10, B_MW = 7'h08,
                         B_RW = 7'h04, B_BERR = 7'h02, B_EXC = 7'h01;
  // control vector: {iord, alusrca, alusrcb[1:0], pcsrc[1:0], extop, regdst, memtoreg, alucont[2:0]}
  localparam logic [11:0] C_IORD = 12'h800, C_SRCA = 12'h400, C_SRCB = 12'h300, C_PCSRC = 12'h0C0,
                          C_EXT = 12'h020, C_RDST = 12'h010, C_M2R = 12'h008, C_ALU = 12'h007;

  logic clk = 1'b0, reset = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic mem_req, pcen, irwrite, memwrite, regwrite, alusrca, iord, memtoreg, regdst, extop;
  logic bus_err, exc;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucont;

  mc_ctrl_fsm #(.ALUC_W(3), .WAIT_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .extop(extop),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucont(alucont), .bus_err(bus_err), .exc(exc)
  );

  always #5 clk = ~clk;

  wire [6:0]  obs_stb = {mem_req, irwrite, pcen, memwrite, regwrite, bus_err, exc};
  wire [11:0] obs_ctl = {iord, alusrca, alusrcb, pcsrc, extop, regdst, memtoreg, alucont};

  typedef struct {
    string      name;
    logic       mr;
    logic       z;
    logic [5:0] op;
    logic [5:0] fn;
    logic [6:0] stb;
    logic [11:0] ctl;
    logic [11:0] care;
  } step_t;

  step_t plan[$];
  logic [5:0] cur_op = 6'd0, cur_fn = 6'd0;
  logic [5:0] op_tab [0:10] = '{LW, SW, RT, BEQ, BNE, ADDI, SLTI, ANDI, ORI, JMP, BAD};
  logic [5:0] fn_tab [0:5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h07};
  int checks = 0, errors = 0;
  bit exc_en;

  localparam logic [11:0] F_CARE = C_IORD | C_SRCA | C_SRCB | C_PCSRC | C_ALU;

  function automatic logic [11:0] cw(input logic io, input logic sa, input logic [1:0] sb,
                                     input logic [1:0] ps, input logic ex, input logic rd,
                                     input logic mt, input logic [2:0] alu);
    return {io, sa, sb, ps, ex, rd, mt, alu};
  endfunction

  function automatic bit fn_known(input logic [5:0] f);
    return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25) || (f == 6'h2a);
  endfunction

  function automatic logic [2:0] fn_alu(input logic [5:0] f);
    case (f)
      6'h22:   return A_SUB;
      6'h24:   return A_AND;
      6'h25:   return A_OR;
      6'h2a:   return A_SLT;
      default: return A_ADD;
    endcase
  endfunction

  function automatic logic [2:0] imm_alu(input logic [5:0] o);
    case (o)
      SLTI:    return A_SLT;
      ANDI:    return A_AND;
      ORI:     return A_OR;
      default: return A_ADD;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // mr/z < 0 means "don't care, randomize"
  task automatic push(input string n, input int mr, input int z, input logic [6:0] stb,
                      input logic [11:0] ctl, input logic [11:0] care);
    step_t s;
    s.name = n;
    s.mr   = (mr < 0) ? 1'($urandom_range(0, 1)) : 1'(mr);
    s.z    = (z < 0) ? 1'($urandom_range(0, 1)) : 1'(z);
    s.op   = cur_op;
    s.fn   = cur_fn;
    s.stb  = stb;
    s.ctl  = ctl;
    s.care = care;
    plan.push_back(s);
  endtask

  // w idle cycles, then either completion (mem_ready=1) or, after 15 waits, the timeout cycle
  task automatic mem_phase(input string n, input int w, input bit tmo, input logic [6:0] done_stb,
                           input logic [11:0] ctl, input logic [11:0] care);
    for (int i = 0; i < w; i++) push(n, 0, -1, B_MREQ, ctl, care);
    if (tmo) push({n, "_timeout"}, 0, -1, B_MREQ | B_BERR, ctl, care);
    else     push(n, 1, -1, B_MREQ | done_stb, ctl, care);
  endtask

  task automatic add_instr(input logic [5:0] o, input logic [5:0] f, input int wf, input int wm,
                           input bit tmo, input int zb);
    bit ext;
    cur_op = o;
    cur_fn = f;
    mem_phase("fetch", wf, 1'b0, B_IRW | B_PCEN, cw(0, 0, 2'b01, 2'b00, 0, 0, 0, A_ADD), F_CARE);
    push("decode", -1, -1, 7'h00, cw(0, 0, 2'b11, 2'b00, 0, 0, 0, A_ADD), C_SRCB | C_ALU);
    case (o)
      LW, SW: begin
        push("memadr", -1, -1, 7'h00, cw(0, 1, 2'b10, 2'b00, 1, 0, 0, A_ADD),
             C_SRCA | C_SRCB | C_EXT | C_ALU);
        if (o == LW) begin
          mem_phase("memrd", wm, tmo, 7'h00, cw(1, 0, 2'b00, 2'b00, 0, 0, 0, A_ADD), C_IORD);
          if (!tmo) push("memwb", -1, -1, B_RW, cw(0, 0, 2'b00, 2'b00, 0, 0, 1, A_ADD), C_RDST | C_M2R);
        end else begin
          mem_phase("memwr", wm, tmo, B_MW, cw(1, 0, 2'b00, 2'b00, 0, 0, 0, A_ADD), C_IORD);
        end
      end
      RT: begin
        push("rtypeex", -1, -1, 7'h00, cw(0, 1, 2'b00, 2'b00, 0, 0, 0, fn_alu(f)), C_SRCA | C_SRCB | C_ALU);
        if (exc_en && !fn_known(f))
          push("exc_funct", -1, -1, B_PCEN | B_EXC, cw(0, 0, 2'b00, 2'b11, 0, 0, 0, A_ADD), C_PCSRC);
        else
          push("rtypewb", -1, -1, B_RW, cw(0, 0, 2'b00, 2'b00, 0, 1, 0, A_ADD), C_RDST);
      end
      BEQ, BNE: begin
        push((o == BEQ) ? "beqex" : "bneex", -1, zb,
             (((o == BEQ) ? zb : 1 - zb) != 0) ? B_PCEN : 7'h00,
             cw(0, 1, 2'b00, 2'b01, 0, 0, 0, A_SUB), C_SRCA | C_SRCB | C_PCSRC | C_ALU);
      end
      ADDI, SLTI, ANDI, ORI: begin
        ext = !(o == ANDI || o == ORI);
        push("immex", -1, -1, 7'h00, cw(0, 1, 2'b10, 2'b00, ext, 0, 0, imm_alu(o)),
             C_SRCA | C_SRCB | C_EXT | C_ALU);
        push("immwb", -1, -1, B_RW, cw(0, 0, 2'b00, 2'b00, 0, 0, 0, A_ADD), C_RDST | C_M2R);
      end
      JMP: push("jex", -1, -1, B_PCEN, cw(0, 0, 2'b00, 2'b10, 0, 0, 0, A_ADD), C_PCSRC);
      default: begin
        if (exc_en)
          push("exc_op", -1, -1, B_PCEN | B_EXC, cw(0, 0, 2'b00, 2'b11, 0, 0, 0, A_ADD), C_PCSRC);
      end
    endcase
  endtask

  task automatic run_plan();
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      op        = s.op;
      funct     = s.fn;
      mem_ready = s.mr;
      zero      = s.z;
      @(negedge clk);
      check({s.name, "/strobes"}, 32'(obs_stb), 32'(s.stb));
      check({s.name, "/ctl"}, 32'(obs_ctl & s.care), 32'(s.ctl & s.care));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int o_i, f_i;
    exc_en = 1'b0;
`ifdef MC_EXC_EN
    exc_en = 1'b1;
`endif
    // Reset state: FETCH controls, strobes held low even with mem_ready high
    reset = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("reset/strobes", 32'(obs_stb), 32'(B_MREQ));
    check("reset/ctl", 32'(obs_ctl & F_CARE), 32'(cw(0, 0, 2'b01, 2'b00, 0, 0, 0, A_ADD) & F_CARE));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset asserted mid-MEMRD returns to FETCH at once
    cur_op = LW;
    cur_fn = 6'd0;
    mem_phase("fetch", 0, 1'b0, B_IRW | B_PCEN, cw(0, 0, 2'b01, 2'b00, 0, 0, 0, A_ADD), F_CARE);
    push("decode", -1, -1, 7'h00, cw(0, 0, 2'b11, 2'b00, 0, 0, 0, A_ADD), C_SRCB | C_ALU);
    push("memadr", -1, -1, 7'h00, cw(0, 1, 2'b10, 2'b00, 1, 0, 0, A_ADD), C_SRCA | C_SRCB | C_EXT | C_ALU);
    push("memrd", 0, -1, B_MREQ, cw(1, 0, 2'b00, 2'b00, 0, 0, 0, A_ADD), C_IORD);
    push("memrd", 0, -1, B_MREQ, cw(1, 0, 2'b00, 2'b00, 0, 0, 0, A_ADD), C_IORD);
    run_plan();
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("midrd_reset/strobes", 32'(obs_stb), 32'(B_MREQ));
    check("midrd_reset/iord", 32'(iord), 32'd0);
    @(negedge clk);
    check("midrd_reset_hold/strobes", 32'(obs_stb), 32'(B_MREQ));
    @(posedge clk);
    #1;
    reset = 1'b0;

    add_instr(LW, 6'd0, 1, 0, 1'b0, 0);
    add_instr(LW, 6'd0, 3, 3, 1'b0, 0);
    add_instr(BEQ, 6'd0, 0, 0, 1'b0, 1);
    add_instr(BEQ, 6'd0, 1, 0, 1'b0, 0);
    add_instr(BNE, 6'd0, 0, 0, 1'b0, 1);
    add_instr(BNE, 6'd0, 2, 0, 1'b0, 0);
    add_instr(ORI, 6'd0, 0, 0, 1'b0, 0);
    add_instr(SLTI, 6'd0, 0, 0, 1'b0, 0);
    add_instr(ANDI, 6'd0, 1, 0, 1'b0, 0);
    add_instr(ADDI, 6'd0, 0, 0, 1'b0, 0);
    add_instr(SW, 6'd0, 0, 15, 1'b1, 0);
    add_instr(SW, 6'd0, 0, 15, 1'b0, 0);
    add_instr(LW, 6'd0, 0, 15, 1'b1, 0);
    add_instr(LW, 6'd0, 0, 14, 1'b0, 0);
    cur_op = JMP;
    mem_phase("fetch", 15, 1'b1, B_IRW | B_PCEN, cw(0, 0, 2'b01, 2'b00, 0, 0, 0, A_ADD), F_CARE);
    add_instr(JMP, 6'd0, 0, 0, 1'b0, 0);
    add_instr(BAD, 6'd0, 0, 0, 1'b0, 0);
    for (int i = 0; i < 6; i++) add_instr(RT, fn_tab[i], 0, 0, 1'b0, 0);
    run_plan();

    for (int i = 0; i < 40; i++) begin
      o_i = int'($urandom_range(0, 10));
      f_i = int'($urandom_range(0, 5));
      add_instr(op_tab[o_i], fn_tab[f_i], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'b0, int'($urandom_range(0, 1)));
    end
    run_plan();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
